rv32imf_fp_dispatch: RTL
========================

RV32IMF_FP_DISPATCH -- requirements
Module: rv32imf_fp_dispatch

Interface
REQ-001 SHALL use parameter DEPTH, default FP_DISP_DEPTH (4), meaning the number of in-flight tag FIFO entries (power of two, 2..8).
REQ-002 SHALL have one clock, clk_i; reset is rst_i, synchronous and active-high.
REQ-003 Ports, clock and reset first:
 clk_i  in  1  clock
 rst_i  in  1  sync active-high reset
 req_valid_i  in  1  core FP request valid
 req_ready_o  out  1  request accepted this cycle
 req_operands_i  in  APU_NARGS_CPUx32  operands
 req_op_i  in  APU_WOP_CPU  {vec, op_mod, op}
 req_flags_i  in  APU_NDSFLAGS_CPU  {int_fmt, src_fmt, dst_fmt, rm}
 req_waddr_i  in  5  destination register
 req_wfp_i  in  1  destination is the FP register file
 req_lat_class_i  in  2  FPU latency class of the op
 apu_req_o  out  1  FPU request
 apu_gnt_i  in  1  FPU grant
 apu_operands_o / apu_op_o / apu_flags_o  out  as req_*  held payload
 apu_rvalid_i  in  1  FPU result valid (never back-pressured)
 apu_rdata_i  in  32  FPU result
 apu_rflags_i  in  APU_NUSFLAGS_CPU  FPU status
 wb_valid_o  out  1  writeback valid
 wb_waddr_o  out  5  writeback register
 wb_wfp_o  out  1  writeback register file select
 wb_wdata_o  out  32  writeback data
 wb_fflags_o  out  APU_NUSFLAGS_CPU  per-op flags
 fflags_acc_o  out  APU_NUSFLAGS_CPU  sticky OR of flags
 fflags_clr_i  in  1  clear the sticky flags
 hz_raddr_i  in  3x5  source registers of the decoding instruction
 hz_rfp_i  in  3  per-source FP register file select
 hazard_o  out  1  source matches a pending destination
 busy_o  out  1  hold register or FIFO non-empty
 err_o  out  1  sticky protocol error

Function
REQ-004 The hold register SHALL hold one request with tag {waddr, wfp, lat_class}; FSM states are IDLE (empty), ISSUE (apu_req_o=1) and DRAIN (held, class blocked).
REQ-005 The block SHALL define occupancy as fifo_count + hold_valid, taken from registered state only.
REQ-006 req_ready_o SHALL equal (!hold_valid | (apu_req_o & apu_gnt_i)) & (occupancy < DEPTH).
REQ-007 On acceptance the payload SHALL be registered; apu_req_o rises the next cycle at the earliest.
REQ-008 From IDLE, acceptance SHALL go to ISSUE if the FIFO is empty or the class equals last_class, and to DRAIN otherwise.
REQ-009 In DRAIN, apu_req_o SHALL be 0, and the block SHALL go to ISSUE on the cycle after the FIFO empties.
REQ-010 In ISSUE, apu_req_o and the payload SHALL stay stable until apu_gnt_i.
REQ-011 On grant the tag SHALL be pushed to the FIFO, last_class SHALL be updated, and the block SHALL go to IDLE, or re-evaluate REQ-008 if a new request is accepted the same cycle (back-to-back).
REQ-012 On apu_rvalid_i the FIFO head SHALL be popped; a simultaneous push and pop SHALL leave the count unchanged.
REQ-013 On apu_rvalid_i with an empty FIFO, the block SHALL ignore the pop and set err_o (sticky).
REQ-014 Writeback SHALL be registered, 1 cycle after apu_rvalid_i: wb_valid_o=1 with head tag, apu_rdata_i and apu_rflags_i; otherwise wb_valid_o=0.
REQ-015 fflags_acc_o SHALL be OR-ed with wb_fflags_o when wb_valid_o is 1; fflags_clr_i SHALL clear it, and when both occur in the same cycle the clear happens first, then the OR is applied.
REQ-016 hazard_o (combinational) SHALL be 1 if any valid FIFO entry or the hold register has waddr==hz_raddr_i[k] and wfp==hz_rfp_i[k] for some k; x0 with wfp=0 never hazards.
REQ-017 Pointers SHALL wrap modulo DEPTH; the full FIFO is distinguished from the empty FIFO by fifo_count.

Reset
REQ-018 On rst_i the block SHALL go to IDLE, with hold_valid, pointers, fifo_count, last_class, wb_* outputs, fflags_acc_o and err_o all 0.
REQ-019 Reset mid-operation SHALL discard held and in-flight tags; FPU results arriving after reset set err_o.

Structure
REQ-020 FP_DISP_DEPTH and typedef fp_disp_tag_t {waddr, wfp, lat_class} SHALL reside in rv32imf_apu_core_pkg.
REQ-021 The tag FIFO SHALL be sub-module rv32imf_fp_tag_fifo (push/pop/count/entry-valid vector for hazard compare).

Verification
REQ-022 Single op: accept FADD (waddr=5, wfp=1), grant at cycle 1, rvalid at cycle 3 with data 0x3F800000 -> wb_valid_o at cycle 4, waddr=5, data 0x3F800000.
REQ-023 Grant withheld 3 cycles -> apu_req_o stays 1, payload stable, req_ready_o=0.
REQ-024 DEPTH=4: issue 4 ops, no rvalid -> req_ready_o=0 on the 5th; one rvalid -> ready again the next cycle.
REQ-025 Class 0 op in flight, then class 1 op -> DRAIN, apu_req_o=0 until the FIFO empties, then issue.
REQ-026 In-flight waddr=7 wfp=1 with hz_raddr_i[1]=7 and hz_rfp_i[1]=1 -> hazard_o=1; same address with wfp=0 -> 0.
REQ-027 apu_rvalid_i with an empty FIFO -> err_o=1 and wb_valid_o=0; rst_i clears err_o.

Source files
------------

// File: rtl/rv32imf_apu_core_pkg.sv
// Shared FPU-interface widths, dispatch tag type and helpers for the RV32IMF APU slice.
package rv32imf_apu_core_pkg;

    localparam int unsigned FP_DISP_DEPTH    = 4;
    localparam int unsigned APU_NARGS_CPU    = 3;
    localparam int unsigned APU_WOP_CPU      = 6;
    localparam int unsigned APU_NDSFLAGS_CPU = 15;
    localparam int unsigned APU_NUSFLAGS_CPU = 5;

    typedef struct packed {
        logic [4:0] waddr;
        logic       wfp;
        logic [1:0] lat_class;
    } fp_disp_tag_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } fp_disp_state_e;

    // Destination match ignores the latency class.
    localparam logic [7:0] TAG_HZ_MASK = 8'b11111_1_00;

    function automatic logic tag_hit(input fp_disp_tag_t t, input logic [4:0] addr, input logic fp);
        fp_disp_tag_t probe;
        probe = '{waddr: addr, wfp: fp, lat_class: 2'b00};
        return ((t ^ probe) & TAG_HZ_MASK) == 8'h00;
    endfunction

endpackage

// File: rtl/rv32imf_fp_tag_fifo.sv
// In-flight destination tag FIFO; exposes every entry plus a valid vector for hazard checks.
module rv32imf_fp_tag_fifo
    import rv32imf_apu_core_pkg::*;
#(
    parameter int unsigned DEPTH = FP_DISP_DEPTH
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  fp_disp_tag_t                   push_tag_i,
    input  logic                           pop_i,
    output logic [4:0]                     head_waddr_o,
    output logic                           head_wfp_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output fp_disp_tag_t [DEPTH-1:0]       entries_o,
    output logic [DEPTH-1:0]               valid_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fp_disp_tag_t [DEPTH-1:0] r_mem;
    logic [PW-1:0]            r_wr_ptr;
    logic [PW-1:0]            r_rd_ptr;
    logic [CW-1:0]            r_count;
    logic                     w_pop;

    assign w_pop = pop_i & (r_count != '0);

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= push_tag_i;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count separates full from empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({push_i, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        valid_o = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            logic [PW-1:0] off;
            off        = PW'(i) - r_rd_ptr;
            valid_o[i] = CW'(off) < r_count;
        end
    end

    assign head_waddr_o = r_mem[r_rd_ptr].waddr;
    assign head_wfp_o   = r_mem[r_rd_ptr].wfp;
    assign count_o      = r_count;
    assign entries_o    = r_mem;

endmodule

// File: rtl/rv32imf_fp_dispatch.sv
// FP request dispatcher: holds one request for the FPU, tracks in-flight tags and writes results back in order.
module rv32imf_fp_dispatch
    import rv32imf_apu_core_pkg::*;
#(
    parameter int unsigned DEPTH = FP_DISP_DEPTH
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic [APU_NARGS_CPU*32-1:0]    req_operands_i,
    input  logic [APU_WOP_CPU-1:0]         req_op_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]    req_flags_i,
    input  logic [4:0]                     req_waddr_i,
    input  logic                           req_wfp_i,
    input  logic [1:0]                     req_lat_class_i,
    output logic                           apu_req_o,
    input  logic                           apu_gnt_i,
    output logic [APU_NARGS_CPU*32-1:0]    apu_operands_o,
    output logic [APU_WOP_CPU-1:0]         apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]    apu_flags_o,
    input  logic                           apu_rvalid_i,
    input  logic [31:0]                    apu_rdata_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]    apu_rflags_i,
    output logic                           wb_valid_o,
    output logic [4:0]                     wb_waddr_o,
    output logic                           wb_wfp_o,
    output logic [31:0]                    wb_wdata_o,
    output logic [APU_NUSFLAGS_CPU-1:0]    wb_fflags_o,
    output logic [APU_NUSFLAGS_CPU-1:0]    fflags_acc_o,
    input  logic                           fflags_clr_i,
    input  logic [2:0][4:0]                hz_raddr_i,
    input  logic [2:0]                     hz_rfp_i,
    output logic                           hazard_o,
    output logic                           busy_o,
    output logic                           err_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fp_disp_state_e                r_state, w_state_nx;
    logic [APU_NARGS_CPU*32-1:0]   r_operands;
    logic [APU_WOP_CPU-1:0]        r_op;
    logic [APU_NDSFLAGS_CPU-1:0]   r_flags;
    fp_disp_tag_t                  r_tag;
    logic [1:0]                    r_last_class;
    logic                          r_wb_valid;
    logic [4:0]                    r_wb_waddr;
    logic                          r_wb_wfp;
    logic [31:0]                   r_wb_wdata;
    logic [APU_NUSFLAGS_CPU-1:0]   r_wb_fflags;
    logic [APU_NUSFLAGS_CPU-1:0]   r_fflags_acc;
    logic                          r_err;

    logic [CW-1:0]                 w_count;
    logic [CW:0]                   w_occ;
    fp_disp_tag_t [DEPTH-1:0]      w_entries;
    logic [DEPTH-1:0]              w_valid;
    logic [4:0]                    w_head_waddr;
    logic                          w_head_wfp;
    logic                          w_hold_valid;
    logic                          w_grant;
    logic                          w_accept;
    logic                          w_pop;
    logic [1:0]                    w_last_class_nx;
    logic                          w_fifo_empty_nx;
    logic                          w_class_ok;
    logic                          w_hazard;

    rv32imf_fp_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (w_grant),
        .push_tag_i   (r_tag),
        .pop_i        (apu_rvalid_i),
        .head_waddr_o (w_head_waddr),
        .head_wfp_o   (w_head_wfp),
        .count_o      (w_count),
        .entries_o    (w_entries),
        .valid_o      (w_valid)
    );

    assign w_hold_valid = (r_state != ST_IDLE);
    assign w_occ        = (CW+1)'(w_count) + (CW+1)'(w_hold_valid);
    assign w_grant      = apu_req_o & apu_gnt_i;
    assign req_ready_o  = (!w_hold_valid | w_grant) & (w_occ < (CW+1)'(DEPTH));
    assign w_accept     = req_valid_i & req_ready_o;
    assign w_pop        = apu_rvalid_i & (w_count != '0);

    // Class check sees the FIFO and last class as they will be after this cycle's grant/pop.
    assign w_last_class_nx = w_grant ? r_tag.lat_class : r_last_class;
    assign w_fifo_empty_nx = !w_grant & ((w_count == '0) | ((w_count == CW'(1)) & w_pop));
    assign w_class_ok      = w_fifo_empty_nx | (req_lat_class_i == w_last_class_nx);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nx = w_class_ok ? ST_ISSUE : ST_DRAIN;
                end
            end
            ST_ISSUE: begin
                if (w_grant) begin
                    if (w_accept) begin
                        w_state_nx = w_class_ok ? ST_ISSUE : ST_DRAIN;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_count == '0) begin
                    w_state_nx = ST_ISSUE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_operands <= req_operands_i;
            r_op       <= req_op_i;
            r_flags    <= req_flags_i;
            r_tag      <= '{waddr: req_waddr_i, wfp: req_wfp_i, lat_class: req_lat_class_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_class <= '0;
            r_wb_valid   <= 1'b0;
            r_wb_waddr   <= '0;
            r_wb_wfp     <= 1'b0;
            r_wb_wdata   <= '0;
            r_wb_fflags  <= '0;
            r_fflags_acc <= '0;
            r_err        <= 1'b0;
        end else begin
            r_last_class <= w_last_class_nx;
            r_wb_valid   <= w_pop;
            if (w_pop) begin
                r_wb_waddr  <= w_head_waddr;
                r_wb_wfp    <= w_head_wfp;
                r_wb_wdata  <= apu_rdata_i;
                r_wb_fflags <= apu_rflags_i;
            end
            // Clear takes effect before the OR of a coincident writeback.
            if (fflags_clr_i) begin
                r_fflags_acc <= r_wb_valid ? r_wb_fflags : '0;
            end else if (r_wb_valid) begin
                r_fflags_acc <= r_fflags_acc | r_wb_fflags;
            end
            if (apu_rvalid_i && (w_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // x0 in the integer file is never a real dependency.
    always_comb begin
        w_hazard = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!((hz_raddr_i[k] == 5'd0) && !hz_rfp_i[k])) begin
                if (w_hold_valid && tag_hit(r_tag, hz_raddr_i[k], hz_rfp_i[k])) begin
                    w_hazard = 1'b1;
                end
                for (int e = 0; e < int'(DEPTH); e++) begin
                    if (w_valid[e] && tag_hit(w_entries[e], hz_raddr_i[k], hz_rfp_i[k])) begin
                        w_hazard = 1'b1;
                    end
                end
            end
        end
    end

    assign apu_req_o      = (r_state == ST_ISSUE);
    assign apu_operands_o = r_operands;
    assign apu_op_o       = r_op;
    assign apu_flags_o    = r_flags;
    assign wb_valid_o     = r_wb_valid;
    assign wb_waddr_o     = r_wb_waddr;
    assign wb_wfp_o       = r_wb_wfp;
    assign wb_wdata_o     = r_wb_wdata;
    assign wb_fflags_o    = r_wb_fflags;
    assign fflags_acc_o   = r_fflags_acc;
    assign hazard_o       = w_hazard;
    assign busy_o         = w_hold_valid | (w_count != '0);
    assign err_o          = r_err;

endmodule
